// File: rtl/atm_cash_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : atm_cash_dispenser
// Purpose  : Converts a withdrawal amount into greedy, stock-limited note
//            eject commands. Optional macro: DISPENSE_TIMEOUT_EN (ack timeout).
// Revision : 1.0 - initial release
// ============================================================================
module atm_cash_dispenser #(
    parameter int CASH_W      = 10,
    parameter int CNT_W       = 8,
    parameter int INIT_N100   = 20,
    parameter int INIT_N50    = 20,
    parameter int INIT_N20    = 20,
    parameter int INIT_N10    = 20,
    parameter int NOTE_GAP    = 2,
    parameter int ACK_TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cash_valid,
    input  logic [CASH_W-1:0] cash_amount,
    output logic              cash_ready,
    output logic              note_req,
    output logic [1:0]        note_denom,
    input  logic              note_ack,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    input  logic              refill,
    input  logic [1:0]        refill_denom,
    input  logic [CNT_W-1:0]  refill_count
);

    localparam int PW = (CASH_W > CNT_W) ? CASH_W : CNT_W;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_PLAN     = 3'd2,
        S_DISPENSE = 3'd3,
        S_GAP      = 3'd4,
        S_FINISH   = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    state_t            r_state, w_next;
    logic [CASH_W-1:0] r_rem;
    logic [1:0]        r_pidx;
    logic [CNT_W-1:0]  r_inv  [4];
    logic [CNT_W-1:0]  r_plan [4];
    logic [3:0]        r_gap;
    logic [1:0]        r_err_code;

    logic [CASH_W-1:0] w_q;
    logic [6:0]        w_dval;
    logic [PW-1:0]     w_take;
    logic [PW+6:0]     w_prod;
    logic [CASH_W-1:0] w_rem_next;
    logic              w_not_mult10;
    logic [1:0]        w_sel;
    logic              w_any_plan;
    logic              w_ack_take;
    logic              w_gap_end;
    logic [CNT_W:0]    w_sum;
    logic [CNT_W-1:0]  w_refill_val;
    logic              w_tmo_hit;

    if (NOTE_GAP < 1 || NOTE_GAP > 15 || ACK_TIMEOUT < 1) begin : g_bad_cfg
        $error("atm_cash_dispenser: NOTE_GAP must be 1..15 and ACK_TIMEOUT >= 1");
    end

`ifdef DISPENSE_TIMEOUT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] r_tmo;

    assign w_tmo_hit = (r_state == S_DISPENSE) && !note_ack &&
                       (r_tmo == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
        end else if (r_state == S_DISPENSE && !note_ack && !w_tmo_hit) begin
            r_tmo <= r_tmo + 1'b1;
        end else begin
            r_tmo <= '0;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    // Greedy step for the denomination currently being planned.
    always_comb begin
        w_dval = 7'd10;
        w_q    = r_rem / CASH_W'(10);
        case (r_pidx)
            2'd3: begin w_dval = 7'd100; w_q = r_rem / CASH_W'(100); end
            2'd2: begin w_dval = 7'd50;  w_q = r_rem / CASH_W'(50);  end
            2'd1: begin w_dval = 7'd20;  w_q = r_rem / CASH_W'(20);  end
            default: ;
        endcase
        w_take     = (PW'(w_q) < PW'(r_inv[r_pidx])) ? PW'(w_q) : PW'(r_inv[r_pidx]);
        w_prod     = (PW+7)'(w_take) * (PW+7)'(w_dval);
        w_rem_next = r_rem - w_prod[CASH_W-1:0];
    end

    assign w_not_mult10 = (r_rem % CASH_W'(10)) != '0;

    // Highest denomination with notes still owed wins.
    always_comb begin
        w_sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_plan[i] != '0) w_sel = 2'(i);
        end
    end

    assign w_any_plan   = (r_plan[0] != '0) || (r_plan[1] != '0) ||
                          (r_plan[2] != '0) || (r_plan[3] != '0);
    assign w_ack_take   = (r_state == S_DISPENSE) && note_ack;
    assign w_gap_end    = (r_gap == 4'(NOTE_GAP - 1));
    assign w_sum        = {1'b0, r_inv[refill_denom]} + {1'b0, refill_count};
    assign w_refill_val = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        cash_ready = 1'b0;
        busy       = 1'b1;
        note_req   = 1'b0;
        note_denom = 2'd0;
        done       = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                cash_ready = 1'b1;
                busy       = 1'b0;
                if (cash_valid) w_next = S_CHECK;
            end
            S_CHECK: begin
                if (w_not_mult10)     w_next = S_FAIL;
                else if (r_rem == '0) w_next = S_FINISH;
                else                  w_next = S_PLAN;
            end
            S_PLAN: begin
                if (r_pidx == 2'd0) w_next = (w_rem_next != '0) ? S_FAIL : S_DISPENSE;
            end
            S_DISPENSE: begin
                note_req   = 1'b1;
                note_denom = w_sel;
                if (w_ack_take)     w_next = S_GAP;
                else if (w_tmo_hit) w_next = S_FAIL;
            end
            S_GAP: begin
                if (w_gap_end) w_next = w_any_plan ? S_DISPENSE : S_FINISH;
            end
            S_FINISH: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_FAIL: begin
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inv[3]   <= CNT_W'(INIT_N100);
            r_inv[2]   <= CNT_W'(INIT_N50);
            r_inv[1]   <= CNT_W'(INIT_N20);
            r_inv[0]   <= CNT_W'(INIT_N10);
            for (int i = 0; i < 4; i++) r_plan[i] <= '0;
            r_rem      <= '0;
            r_pidx     <= 2'd0;
            r_gap      <= 4'd0;
            r_err_code <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cash_valid) r_rem <= cash_amount;
                    if (refill)     r_inv[refill_denom] <= w_refill_val;
                end
                S_CHECK: begin
                    for (int i = 0; i < 4; i++) r_plan[i] <= '0;
                    r_pidx <= 2'd3;
                    if (w_not_mult10) r_err_code <= 2'd1;
                end
                S_PLAN: begin
                    r_plan[r_pidx] <= w_take[CNT_W-1:0];
                    r_rem          <= w_rem_next;
                    r_pidx         <= r_pidx - 2'd1;
                    // A failed plan must leave nothing owed, so nothing is dispensed.
                    if (r_pidx == 2'd0 && w_rem_next != '0) begin
                        r_err_code <= 2'd2;
                        for (int i = 0; i < 4; i++) r_plan[i] <= '0;
                    end
                end
                S_DISPENSE: begin
                    r_gap <= 4'd0;
                    if (w_ack_take) begin
                        r_plan[w_sel] <= r_plan[w_sel] - 1'b1;
                        r_inv[w_sel]  <= r_inv[w_sel] - 1'b1;
                    end else if (w_tmo_hit) begin
                        r_err_code <= 2'd3;
                        for (int i = 0; i < 4; i++) r_plan[i] <= '0;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_atm_cash_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_atm_cash_dispenser
// Purpose  : Directed self-checking bench; instance A uses default stock,
//            instance B starts with one 100 note and no 20/10 notes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atm_cash_dispenser;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       cv   [2];
    logic [9:0] amt  [2];
    logic       ack  [2];
    logic       rf   [2];
    logic [1:0] rfd  [2];
    logic [7:0] rfc  [2];
    logic       rdy  [2];
    logic       req  [2];
    logic [1:0] den  [2];
    logic       bsy  [2];
    logic       dn   [2];
    logic       er   [2];
    logic [1:0] ec   [2];

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] notes[$];
    int first_req, done_cyc, err_cyc, gap_bad, gap_n, req_cycles;

    atm_cash_dispenser #(.ACK_TIMEOUT(8)) dut_a (
        .clk(clk), .rst(rst),
        .cash_valid(cv[0]), .cash_amount(amt[0]), .cash_ready(rdy[0]),
        .note_req(req[0]), .note_denom(den[0]), .note_ack(ack[0]),
        .busy(bsy[0]), .done(dn[0]), .err(er[0]), .err_code(ec[0]),
        .refill(rf[0]), .refill_denom(rfd[0]), .refill_count(rfc[0])
    );

    atm_cash_dispenser #(.INIT_N100(1), .INIT_N20(0), .INIT_N10(0), .ACK_TIMEOUT(8)) dut_b (
        .clk(clk), .rst(rst),
        .cash_valid(cv[1]), .cash_amount(amt[1]), .cash_ready(rdy[1]),
        .note_req(req[1]), .note_denom(den[1]), .note_ack(ack[1]),
        .busy(bsy[1]), .done(dn[1]), .err(er[1]), .err_code(ec[1]),
        .refill(rf[1]), .refill_denom(rfd[1]), .refill_count(rfc[1])
    );

    // Cycle 1 is the cycle right after the accept edge (CHECK).
    task automatic run_txn(input int s, input logic [9:0] amount, input bit do_ack,
                           input int maxcyc);
        bit prev_req = 1'b0;
        bit ended    = 1'b0;
        bit started  = 1'b0;
        int low_run  = 0;
        notes.delete();
        first_req = -1; done_cyc = -1; err_cyc = -1;
        gap_bad = 0; gap_n = 0; req_cycles = 0;
        cv[s] = 1'b1; amt[s] = amount;
        @(posedge clk); #1;
        cv[s] = 1'b0;
        for (int cyc = 2; cyc <= maxcyc && !ended; cyc++) begin
            @(posedge clk); #1;
            if (ack[s]) begin
                ack[s] = 1'b0;
            end else if (req[s] && prev_req && do_ack) begin
                ack[s] = 1'b1;
                notes.push_back(den[s]);
            end
            if (req[s]) begin
                req_cycles++;
                if (first_req < 0) first_req = cyc;
                if (started && low_run > 0) begin
                    gap_n++;
                    if (low_run != 2) gap_bad++;
                end
                started = 1'b1;
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_req = req[s];
            if (dn[s]) begin done_cyc = cyc; ended = 1'b1; end
            if (er[s]) begin err_cyc  = cyc; ended = 1'b1; end
        end
        if (ended) begin
            @(posedge clk); #1;
        end else if (do_ack) begin
            n_checks++; n_fail++;
            $display("FAIL txn_bound: no done/err within %0d cycles (amount %0d)", maxcyc, amount);
        end
    endtask

    task automatic do_refill(input int s, input logic [1:0] d, input logic [7:0] c);
        rf[s] = 1'b1; rfd[s] = d; rfc[s] = c;
        @(posedge clk); #1;
        rf[s] = 1'b0;
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            n_checks++;
            if ({rdy[s], req[s], den[s], bsy[s], dn[s], er[s], ec[s]} !== 9'b1_0_00_0_0_0_00) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got rdy=%b req=%b den=%0d busy=%b done=%b err=%b ec=%0d, want 1 0 0 0 0 0 0",
                         s, rdy[s], req[s], den[s], bsy[s], dn[s], er[s], ec[s]);
            end
        end
        n_checks++;
        if (dut_a.r_inv[3] !== 8'd20 || dut_b.r_inv[3] !== 8'd1) begin
            n_fail++;
            $display("FAIL reset_inv: got a100=%0d b100=%0d, want 20 1", dut_a.r_inv[3], dut_b.r_inv[3]);
        end
    endtask

    task automatic test_dispense_380();
        logic [1:0] exp_seq [6] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd1, 2'd0};
        logic [7:0] exp_inv [4] = '{8'd19, 8'd19, 8'd19, 8'd17};
        run_txn(0, 10'd380, 1'b1, 200);
        n_checks++;
        if (notes.size() != 6) begin
            n_fail++;
            $display("FAIL seq380_len: got %0d notes, want 6", notes.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (notes[i] !== exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL seq380[%0d]: got denom %0d, want %0d", i, notes[i], exp_seq[i]);
                end
            end
        end
        n_checks++;
        if (first_req != 6) begin
            n_fail++;
            $display("FAIL latency_first_req: got cycle %0d, want 6", first_req);
        end
        n_checks++;
        if (gap_bad != 0 || gap_n != 5) begin
            n_fail++;
            $display("FAIL note_gap: got %0d bad of %0d gaps, want 0 of 5", gap_bad, gap_n);
        end
        n_checks++;
        if (done_cyc < 0 || err_cyc >= 0) begin
            n_fail++;
            $display("FAIL done380: got done_cyc=%0d err_cyc=%0d, want done and no err", done_cyc, err_cyc);
        end
        for (int d = 0; d < 4; d++) begin
            n_checks++;
            if (dut_a.r_inv[d] !== exp_inv[d]) begin
                n_fail++;
                $display("FAIL inv380[%0d]: got %0d, want %0d", d, dut_a.r_inv[d], exp_inv[d]);
            end
        end
    endtask

    task automatic test_bad_and_zero();
        run_txn(0, 10'd25, 1'b1, 30);
        n_checks++;
        if (err_cyc != 2 || ec[0] !== 2'd1 || req_cycles != 0 || done_cyc >= 0) begin
            n_fail++;
            $display("FAIL not_mult10: got err_cyc=%0d ec=%0d reqs=%0d done=%0d, want 2 1 0 -1",
                     err_cyc, ec[0], req_cycles, done_cyc);
        end
        n_checks++;
        if (dut_a.r_inv[3] !== 8'd17 || dut_a.r_inv[0] !== 8'd19) begin
            n_fail++;
            $display("FAIL inv_after_25: got 100s=%0d 10s=%0d, want 17 19", dut_a.r_inv[3], dut_a.r_inv[0]);
        end
        run_txn(0, 10'd0, 1'b1, 30);
        n_checks++;
        if (done_cyc != 2 || req_cycles != 0 || err_cyc >= 0) begin
            n_fail++;
            $display("FAIL zero_amount: got done_cyc=%0d reqs=%0d err_cyc=%0d, want 2 0 -1",
                     done_cyc, req_cycles, err_cyc);
        end
        n_checks++;
        if (ec[0] !== 2'd1) begin
            n_fail++;
            $display("FAIL err_code_hold: got %0d, want 1", ec[0]);
        end
    endtask

    task automatic test_limited_stock();
        logic [1:0] exp_seq [5] = '{2'd3, 2'd2, 2'd2, 2'd2, 2'd2};
        run_txn(1, 10'd300, 1'b1, 200);
        n_checks++;
        if (notes.size() != 5 || done_cyc < 0) begin
            n_fail++;
            $display("FAIL seq300_len: got %0d notes done_cyc=%0d, want 5 notes and done", notes.size(), done_cyc);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (notes[i] !== exp_seq[i]) begin
                    n_fail++;
                    $display("FAIL seq300[%0d]: got denom %0d, want %0d", i, notes[i], exp_seq[i]);
                end
            end
        end
        n_checks++;
        if (dut_b.r_inv[3] !== 8'd0 || dut_b.r_inv[2] !== 8'd16) begin
            n_fail++;
            $display("FAIL inv300: got 100s=%0d 50s=%0d, want 0 16", dut_b.r_inv[3], dut_b.r_inv[2]);
        end
    endtask

    task automatic test_cannot_make_then_refill();
        run_txn(1, 10'd30, 1'b1, 30);
        n_checks++;
        if (err_cyc != 6 || ec[1] !== 2'd2 || req_cycles != 0) begin
            n_fail++;
            $display("FAIL cannot_make: got err_cyc=%0d ec=%0d reqs=%0d, want 6 2 0", err_cyc, ec[1], req_cycles);
        end
        do_refill(1, 2'd0, 8'd5);
        n_checks++;
        if (dut_b.r_inv[0] !== 8'd5) begin
            n_fail++;
            $display("FAIL refill10: got %0d, want 5", dut_b.r_inv[0]);
        end
        run_txn(1, 10'd30, 1'b1, 100);
        n_checks++;
        if (notes.size() != 3 || done_cyc < 0 || notes[0] !== 2'd0 || notes[2] !== 2'd0) begin
            n_fail++;
            $display("FAIL seq30: got %0d notes done_cyc=%0d, want three 10-notes and done", notes.size(), done_cyc);
        end
        n_checks++;
        if (dut_b.r_inv[0] !== 8'd2) begin
            n_fail++;
            $display("FAIL inv30: got 10s=%0d, want 2", dut_b.r_inv[0]);
        end
    endtask

    task automatic test_reset_mid_dispense();
        bit prev = 1'b0;
        bit got  = 1'b0;
        cv[0] = 1'b1; amt[0] = 10'd200;
        @(posedge clk); #1;
        cv[0] = 1'b0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(posedge clk); #1;
            if (ack[0]) begin
                ack[0] = 1'b0;
                got = 1'b1;
            end else if (req[0] && prev) begin
                ack[0] = 1'b1;
            end
            prev = req[0];
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL mid_first_ack: got no note within 40 cycles, want one");
        end
        do_refill(0, 2'd1, 8'd9);
        n_checks++;
        if (dut_a.r_inv[1] !== 8'd19 || dut_a.r_inv[3] !== 8'd16) begin
            n_fail++;
            $display("FAIL refill_busy: got 20s=%0d 100s=%0d, want 19 16", dut_a.r_inv[1], dut_a.r_inv[3]);
        end
        for (int k = 0; k < 10 && !req[0]; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({rdy[0], req[0], den[0], bsy[0], dn[0], er[0], ec[0]} !== 9'b1_0_00_0_0_0_00) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got rdy=%b req=%b den=%0d busy=%b done=%b err=%b ec=%0d, want 1 0 0 0 0 0 0",
                     rdy[0], req[0], den[0], bsy[0], dn[0], er[0], ec[0]);
        end
        n_checks++;
        if (dut_a.r_inv[3] !== 8'd20 || dut_a.r_inv[1] !== 8'd20) begin
            n_fail++;
            $display("FAIL mid_reset_inv: got 100s=%0d 20s=%0d, want 20 20", dut_a.r_inv[3], dut_a.r_inv[1]);
        end
        @(negedge clk);
        rst = 1'b1;
        begin
            int stray = 0;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (req[0] || bsy[0]) stray++;
            end
            n_checks++;
            if (stray != 0) begin
                n_fail++;
                $display("FAIL no_notes_after_reset: got %0d busy/req cycles, want 0", stray);
            end
        end
    endtask

    task automatic test_refill_saturation();
        do_refill(0, 2'd2, 8'd250);
        n_checks++;
        if (dut_a.r_inv[2] !== 8'd255) begin
            n_fail++;
            $display("FAIL refill_sat: got %0d, want 255", dut_a.r_inv[2]);
        end
        do_refill(0, 2'd0, 8'd3);
        n_checks++;
        if (dut_a.r_inv[0] !== 8'd23 || dut_a.r_inv[2] !== 8'd255) begin
            n_fail++;
            $display("FAIL refill_add: got 10s=%0d 50s=%0d, want 23 255", dut_a.r_inv[0], dut_a.r_inv[2]);
        end
    endtask

    task automatic test_ack_timeout();
        run_txn(0, 10'd100, 1'b0, 30);
`ifdef DISPENSE_TIMEOUT_EN
        n_checks++;
        if (req_cycles != 8 || err_cyc < 0 || ec[0] !== 2'd3 || dut_a.r_inv[3] !== 8'd20) begin
            n_fail++;
            $display("FAIL ack_timeout: got reqs=%0d err_cyc=%0d ec=%0d inv100=%0d, want 8 err 3 20",
                     req_cycles, err_cyc, ec[0], dut_a.r_inv[3]);
        end
`else
        n_checks++;
        if (req_cycles != 25 || err_cyc >= 0 || !req[0] || ec[0] !== 2'd0) begin
            n_fail++;
            $display("FAIL wait_forever: got reqs=%0d err_cyc=%0d req=%b ec=%0d, want 25 -1 1 0",
                     req_cycles, err_cyc, req[0], ec[0]);
        end
`endif
    endtask

    initial begin
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            cv[s] = 1'b0; amt[s] = '0; ack[s] = 1'b0;
            rf[s] = 1'b0; rfd[s] = '0; rfc[s] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        test_dispense_380();
        test_bad_and_zero();
        test_limited_stock();
        test_cannot_make_then_refill();
        test_reset_mid_dispense();
        test_refill_saturation();
        test_ack_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/atm_cash_dispenser.md
Name: atm_cash_dispenser

Overview:
- Physical-output end of the ATM cash path: accepts the withdrawal amount the ATM controller produces on its `cash` output and turns it into individual note-eject commands to the dispenser mechanism.
- Keeps per-denomination note inventory and plans a greedy note mix (100/50/20/10) limited by stock.
- Dispenses one note per mechanism handshake and reports completion or error back to the controller.

Parameters:
- CASH_W, 10, width of the cash amount (matches the ATM `cash` output).
- CNT_W, 8, width of each inventory and plan counter.
- INIT_N100, 20, reset inventory of 100-unit notes.
- INIT_N50, 20, reset inventory of 50-unit notes.
- INIT_N20, 20, reset inventory of 20-unit notes.
- INIT_N10, 20, reset inventory of 10-unit notes.
- NOTE_GAP, 2, idle cycles after each acknowledged note (range 1..15).
- ACK_TIMEOUT, 64, cycles to wait for note_ack (used only with DISPENSE_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cash_valid  in  1  request valid; amount stable while high.
- cash_amount  in  CASH_W  requested amount.
- cash_ready  out  1  high only in IDLE.
- note_req  out  1  eject one note; held until acked.
- note_denom  out  2  0=10, 1=20, 2=50, 3=100; valid while note_req.
- note_ack  in  1  mechanism has taken the note.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  one-cycle pulse on failure.
- err_code  out  2  1=not multiple of 10, 2=cannot make amount, 3=ack timeout; holds last value.
- refill  in  1  add notes (honoured in IDLE only).
- refill_denom  in  2  denomination to refill.
- refill_count  in  CNT_W  notes to add.

Behaviour:
- Reset (rst=0, any time, including mid-dispense) forces state IDLE:
  - cash_ready=1; note_req, note_denom, busy, done, err, err_code = 0.
  - Inventories reload to INIT_*; plan counters are cleared; no further notes are requested.
- States: IDLE, CHECK, PLAN, DISPENSE, GAP, FINISH, FAIL.
- IDLE:
  - cash_valid & cash_ready latches cash_amount; next state CHECK.
  - A refill in the same cycle is still applied.
  - Refill adds refill_count to the selected inventory, saturating at 2^CNT_W-1. Refill is ignored outside IDLE.
- CHECK (1 cycle):
  - amount mod 10 != 0 -> FAIL, code 1.
  - amount == 0 -> FINISH, no notes issued.
  - Otherwise -> PLAN.
- PLAN (4 cycles, one denomination per cycle, 100 then 50, 20, 10):
  - plan_d = min(rem / d, inv_d); rem -= plan_d * d.
  - After the 10-unit cycle: rem != 0 -> FAIL, code 2, inventory untouched. rem == 0 -> DISPENSE.
- DISPENSE:
  - Selects the highest denomination with nonzero plan; asserts note_req with that note_denom.
  - On the first cycle with note_req & note_ack: decrement that plan and inventory by 1; note_req deasserts next cycle; go to GAP.
  - note_ack while note_req=0 is ignored.
- GAP:
  - Waits NOTE_GAP cycles.
  - Then DISPENSE if any plan is nonzero, else FINISH.
- FINISH: done=1 for one cycle -> IDLE.
- FAIL: err=1 for one cycle, err_code updated -> IDLE.
- Latency:
  - Accept to first note_req = 6 cycles (1 CHECK + 4 PLAN + 1).
  - Zero amount: done pulses 2 cycles after accept.
- Notes are never requested before the full plan succeeds; a failed plan dispenses nothing.

Optional Feature:
- Macro DISPENSE_TIMEOUT_EN.
- Defined:
  - A counter runs while note_req is high and note_ack is low.
  - Reaching ACK_TIMEOUT -> note_req drops, plans clear, FAIL with code 3.
  - Notes already acked stay debited; undispensed notes stay in inventory.
- Undefined: DISPENSE waits indefinitely for note_ack; code 3 never occurs.

Test Plan:
- Default inventory, request 380, ack each note after 1 cycle -> note_denom sequence 3,3,3,2,1,0; done pulse; inventories 17/19/19/19; NOTE_GAP spacing between notes.
- Request 25 -> err pulse, err_code=1, no note_req, inventories unchanged; then request 0 -> done 2 cycles after accept.
- INIT_N100=1, request 300 -> sequence 3,2,2,2,2; inv100=0, inv50=16.
- INIT_N10=0, INIT_N20=0, request 30 -> err_code=2, no notes; refill denom 0 count 5 in IDLE, re-request 30 -> notes 1,0 skipped? No: plan 20x0 → notes 0,0,0; done.
- Request 200, assert rst low after first ack -> all outputs reset, inv100 back to 20; a refill issued while busy has no effect.
- With DISPENSE_TIMEOUT_EN, ACK_TIMEOUT=8, request 100, never ack -> note_req high 8 cycles then err, err_code=3, inv100 stays 20.
